// File: rtl/bp_pkg.sv
// Shared branch-predictor table geometry, FSM encoding and PC slicing helpers.
// Used by the table scheduler and by the NPC generator's table read path.
package bp_pkg;

  localparam int         BTB_SET   = 64;
  localparam int         BHT_SET   = 4096;
  localparam logic [1:0] BHT_INIT  = 2'b01;

  localparam int BTB_IDX_W = $clog2(BTB_SET);
  localparam int BHT_IDX_W = $clog2(BHT_SET);
  localparam int BTB_TAG_W = 30 - BTB_IDX_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic [BTB_TAG_W-1:0] btb_tag;
    logic [BTB_IDX_W-1:0] btb_idx;
    logic [BHT_IDX_W-1:0] bht_idx;
  } bp_pc_slice_t;

  // Takes the word address (pc[31:2]); instructions are word aligned.
  function automatic bp_pc_slice_t pc_slice(input logic [29:0] word_addr);
    bp_pc_slice_t s;
    s.btb_tag = word_addr[29:BTB_IDX_W];
    s.btb_idx = word_addr[BTB_IDX_W-1:0];
    s.bht_idx = word_addr[BHT_IDX_W-1:0];
    return s;
  endfunction

endpackage

// File: rtl/bp_sat_counter2.sv
// Two-bit saturating counter step: taken counts up to 3, not-taken down to 0.
// Purely combinational, no backpressure.
module bp_sat_counter2 (
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) cnt_nxt = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) cnt_nxt = cnt - 2'b01;
    end
  end

endmodule

// File: rtl/bp_table_scheduler.sv
// Single write port owner for BTB/BHT: init sweep (BHT_SET cycles) then same-cycle EX updates.
// Updates arriving mid-sweep are dropped and counted; flush_req restarts the sweep and wins over updates.
module bp_table_scheduler
  import bp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_req,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic                 upd_mispredict,
  input  logic [1:0]           bht_rdata,
  output logic                 btb_we,
  output logic [BTB_IDX_W-1:0] btb_waddr,
  output logic [BTB_TAG_W-1:0] btb_wtag,
  output logic [31:0]          btb_wtarget,
  output logic                 btb_wvalid,
  output logic                 bht_we,
  output logic [BHT_IDX_W-1:0] bht_waddr,
  output logic [1:0]           bht_wdata,
  output logic                 pred_enable,
  output logic                 init_busy,
  output logic [63:0]          stat_total,
  output logic [63:0]          stat_correct,
  output logic [31:0]          stat_dropped
);

  if (BTB_SET > BHT_SET || (BTB_SET & (BTB_SET - 1)) != 0 ||
      (BHT_SET & (BHT_SET - 1)) != 0) begin : g_bad_geometry
    $error("bp_table_scheduler: table sizes must be powers of 2 with BTB_SET <= BHT_SET");
  end

  bp_state_e            state, state_nxt;
  logic [BHT_IDX_W-1:0] idx, idx_nxt;
  logic [1:0]           cnt_nxt;
  bp_pc_slice_t         upd_slice;
  logic                 upd_commit;
  logic                 upd_drop;
  logic                 unused_pc_lsb;

  assign upd_slice     = pc_slice(upd_pc[31:2]);
  assign unused_pc_lsb = ^upd_pc[1:0];

  bp_sat_counter2 u_sat (
    .cnt     (bht_rdata),
    .taken   (upd_taken),
    .cnt_nxt (cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    btb_we      = 1'b0;
    btb_waddr   = '0;
    btb_wtag    = '0;
    btb_wtarget = '0;
    btb_wvalid  = 1'b0;
    bht_we      = 1'b0;
    bht_waddr   = '0;
    bht_wdata   = '0;
    pred_enable = 1'b0;
    init_busy   = 1'b1;
    upd_commit  = 1'b0;
    upd_drop    = 1'b0;

    if (!rst) begin
      unique case (state)
        ST_INIT: begin
          // BTB is no larger than the BHT, so it is covered by the first BTB_SET steps.
          bht_we    = 1'b1;
          bht_waddr = idx;
          bht_wdata = BHT_INIT;
          btb_we    = (32'(idx) < 32'(BTB_SET));
          btb_waddr = idx[BTB_IDX_W-1:0];
          idx_nxt   = idx + BHT_IDX_W'(1);
          if (idx == BHT_IDX_W'(BHT_SET - 1)) state_nxt = ST_RUN;
          upd_drop  = upd_valid;
        end
        ST_RUN: begin
          init_busy   = 1'b0;
          pred_enable = 1'b1;
          btb_waddr   = upd_slice.btb_idx;
          btb_wtag    = upd_slice.btb_tag;
          btb_wtarget = upd_target;
          btb_wvalid  = 1'b1;
          bht_waddr   = upd_slice.bht_idx;
          bht_wdata   = cnt_nxt;
          if (upd_valid && !flush_req) begin
            btb_we     = 1'b1;
            bht_we     = 1'b1;
            upd_commit = 1'b1;
          end
        end
      endcase

      if (flush_req) begin
        state_nxt = ST_INIT;
        idx_nxt   = '0;
        upd_drop  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total   <= '0;
      stat_correct <= '0;
      stat_dropped <= '0;
    end else begin
      if (flush_req) begin
        stat_total   <= '0;
        stat_correct <= '0;
      end else if (upd_commit) begin
        stat_total <= stat_total + 64'd1;
        if (!upd_mispredict) stat_correct <= stat_correct + 64'd1;
      end
      if (upd_drop && stat_dropped != '1) stat_dropped <= stat_dropped + 32'd1;
    end
  end

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Directed + randomized bench for bp_table_scheduler against a table/statistics reference model.
module tb_bp_table_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_req;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [1:0]  bht_rdata;
  logic        btb_we;
  logic [5:0]  btb_waddr;
  logic [23:0] btb_wtag;
  logic [31:0] btb_wtarget;
  logic        btb_wvalid;
  logic        bht_we;
  logic [11:0] bht_waddr;
  logic [1:0]  bht_wdata;
  logic        pred_enable;
  logic        init_busy;
  logic [63:0] stat_total;
  logic [63:0] stat_correct;
  logic [31:0] stat_dropped;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the bench plays the BHT storage and tracks expected statistics.
  int              m_bht [4096];
  longint unsigned m_total;
  longint unsigned m_correct;
  longint unsigned m_drop;

  always #5 clk = ~clk;

  bp_table_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .flush_req      (flush_req),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .bht_rdata      (bht_rdata),
    .btb_we         (btb_we),
    .btb_waddr      (btb_waddr),
    .btb_wtag       (btb_wtag),
    .btb_wtarget    (btb_wtarget),
    .btb_wvalid     (btb_wvalid),
    .bht_we         (bht_we),
    .bht_waddr      (bht_waddr),
    .bht_wdata      (bht_wdata),
    .pred_enable    (pred_enable),
    .init_busy      (init_busy),
    .stat_total     (stat_total),
    .stat_correct   (stat_correct),
    .stat_dropped   (stat_dropped)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_tables();
    for (int i = 0; i < 4096; i++) m_bht[i] = 1;
  endtask

  // Runs one sweep from its first cycle; optionally forces an update at sweep step
  // drop_at, random updates at drop_pct percent, and a flush at absolute cycle flush_at.
  task automatic sweep(input int drop_at, input int drop_pct, input int flush_at);
    int c;
    int cyc;
    int exp_len;
    c = 0;
    cyc = 0;
    exp_len = 4096 + ((flush_at >= 0) ? flush_at + 1 : 0);
    while (c < 4096 && cyc < 9000) begin
      upd_valid      = (c == drop_at) || (int'($urandom_range(99)) < drop_pct);
      upd_pc         = $urandom;
      upd_taken      = 1'($urandom);
      upd_target     = $urandom;
      upd_mispredict = 1'($urandom);
      bht_rdata      = 2'($urandom);
      flush_req      = (cyc == flush_at);
      #1;
      chk("sweep_bht_we", bht_we, 1);
      chk("sweep_bht_waddr", bht_waddr, c);
      chk("sweep_bht_wdata", bht_wdata, 2'b01);
      chk("sweep_btb_we", btb_we, (c < 64));
      if (c < 64) begin
        chk("sweep_btb_waddr", btb_waddr, c);
        chk("sweep_btb_wvalid", btb_wvalid, 0);
        chk("sweep_btb_wtag", btb_wtag, 0);
        chk("sweep_btb_wtarget", btb_wtarget, 0);
      end
      chk("sweep_init_busy", init_busy, 1);
      chk("sweep_pred_enable", pred_enable, 0);
      if (upd_valid && !flush_req && m_drop != 64'hFFFF_FFFF) m_drop++;
      @(posedge clk);
      #1;
      c = flush_req ? 0 : c + 1;
      cyc++;
    end
    flush_req = 1'b0;
    upd_valid = 1'b0;
    #1;
    chk("sweep_length", cyc, exp_len);
    chk("run_pred_enable", pred_enable, 1);
    chk("run_init_busy", init_busy, 0);
    chk("stat_dropped", stat_dropped, m_drop);
    model_clear_tables();
  endtask

  // One RUN-state update, checked on its write cycle and on the following statistics.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mis);
    int i;
    int v;
    int e;
    i = int'((pc >> 2) % 4096);
    v = m_bht[i];
    e = tk ? ((v + 1 > 3) ? 3 : v + 1) : ((v - 1 < 0) ? 0 : v - 1);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mis;
    bht_rdata      = 2'(v);
    #1;
    chk("upd_bht_we", bht_we, 1);
    chk("upd_bht_waddr", bht_waddr, i);
    chk("upd_bht_wdata", bht_wdata, e);
    chk("upd_btb_we", btb_we, 1);
    chk("upd_btb_waddr", btb_waddr, (pc >> 2) % 64);
    chk("upd_btb_wtag", btb_wtag, pc >> 8);
    chk("upd_btb_wtarget", btb_wtarget, tgt);
    chk("upd_btb_wvalid", btb_wvalid, 1);
    m_bht[i] = e;
    m_total++;
    if (!mis) m_correct++;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
    chk("stat_total", stat_total, m_total);
    chk("stat_correct", stat_correct, m_correct);
  endtask

  task automatic idle_cycle();
    upd_valid = 1'b0;
    upd_pc    = $urandom;
    bht_rdata = 2'($urandom);
    #1;
    chk("idle_bht_we", bht_we, 0);
    chk("idle_btb_we", btb_we, 0);
    chk("idle_pred_enable", pred_enable, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_pc;
    rst            = 1'b1;
    flush_req      = 1'b0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_mispredict = 1'b0;
    bht_rdata      = 2'b00;
    m_total        = 0;
    m_correct      = 0;
    m_drop         = 0;
    model_clear_tables();

    // Reset: two cycles, with an update offered to prove it is ignored.
    repeat (2) @(posedge clk);
    #1;
    upd_valid = 1'b1;
    #1;
    chk("rst_btb_we", btb_we, 0);
    chk("rst_bht_we", bht_we, 0);
    chk("rst_pred_enable", pred_enable, 0);
    chk("rst_init_busy", init_busy, 1);
    chk("rst_stat_total", stat_total, 0);
    chk("rst_stat_correct", stat_correct, 0);
    chk("rst_stat_dropped", stat_dropped, 0);
    upd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Initial sweep with a lost update at step 100.
    sweep(100, 0, -1);
    chk("drop_after_first_sweep", stat_dropped, 1);

    // Taken update from a weakly-taken counter.
    m_bht[32'h48D] = 2;
    upd(32'h0000_1234, 1'b1, 32'h0000_2000, 1'b0);

    // Saturation corners.
    m_bht[32'h100 >> 2] = 3;
    upd(32'h0000_0100, 1'b1, 32'h0000_4000, 1'b1);
    m_bht[32'h204 >> 2] = 0;
    upd(32'h0000_0204, 1'b0, 32'h0000_4004, 1'b0);
    m_bht[32'h308 >> 2] = 2;
    upd(32'h0000_0308, 1'b0, 32'h0000_4008, 1'b1);
    upd(32'h8000_0010, 1'b1, 32'h0000_400c, 1'b0);
    chk("stat5_total", stat_total, 5);
    chk("stat5_correct", stat_correct, 3);

    // Random updates with frequent reuse of the same PC back-to-back.
    last_pc = 32'h0000_1234;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) idle_cycle();
      if ($urandom_range(2) != 0) last_pc = $urandom;
      upd(last_pc, 1'($urandom), $urandom, 1'($urandom));
    end

    // Flush colliding with an update in RUN.
    flush_req = 1'b1;
    upd_valid = 1'b1;
    upd_pc    = $urandom;
    bht_rdata = 2'($urandom);
    #1;
    chk("flush_bht_we", bht_we, 0);
    chk("flush_btb_we", btb_we, 0);
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    upd_valid = 1'b0;
    m_total   = 0;
    m_correct = 0;
    #1;
    chk("flush_stat_total", stat_total, 0);
    chk("flush_stat_correct", stat_correct, 0);
    chk("flush_init_busy", init_busy, 1);
    chk("flush_bht_waddr", bht_waddr, 0);
    chk("flush_keeps_dropped", stat_dropped, m_drop);

    // Second sweep with random lost updates and a restart partway through.
    sweep(-1, 10, 300);

    for (int n = 0; n < 40; n++) upd($urandom, 1'($urandom), $urandom, 1'($urandom));

    // Reset from RUN clears everything, including the dropped counter.
    rst       = 1'b1;
    upd_valid = 1'b1;
    #1;
    chk("rst2_bht_we", bht_we, 0);
    chk("rst2_btb_we", btb_we, 0);
    chk("rst2_init_busy", init_busy, 1);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    rst       = 1'b0;
    #1;
    chk("rst2_stat_total", stat_total, 0);
    chk("rst2_stat_correct", stat_correct, 0);
    chk("rst2_stat_dropped", stat_dropped, 0);
    chk("rst2_bht_waddr", bht_waddr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_table_scheduler.md
Name: bp_table_scheduler

Overview:
- Owns the single write port of the branch-prediction tables: BTB (64 sets) and BHT (4096 two-bit counters).
- Sequences a multi-cycle initialization sweep after reset or pipeline flush. This replaces the one-cycle loop clear.
- Schedules EX-stage branch updates into the tables and maintains prediction statistics.
- Sits between the EX stage and the table storage. The NPC generator reads the tables and uses pred_enable to gate predictions.

Parameters:
- BTB_SET, 64, number of BTB sets. Power of 2; must be <= BHT_SET (elaboration check).
- BHT_SET, 4096, number of BHT counters. Power of 2.
- BHT_INIT, 2'b01, counter value written by the sweep (weakly not-taken).
- Derived locals: BTB_IDX_W = log2(BTB_SET), BHT_IDX_W = log2(BHT_SET), BTB_TAG_W = 30 - BTB_IDX_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_req  in  1  restart the sweep and clear statistics.
- upd_valid  in  1  resolved branch in EX (is_br && !bubble).
- upd_pc  in  32  PC of the branch in EX.
- upd_taken  in  1  branch outcome.
- upd_target  in  32  branch target.
- upd_mispredict  in  1  prediction was wrong.
- bht_rdata  in  2  BHT counter at bht_waddr (combinational table read).
- btb_we  out  1  BTB write enable.
- btb_waddr  out  BTB_IDX_W  BTB write index.
- btb_wtag  out  BTB_TAG_W  BTB write tag.
- btb_wtarget  out  32  BTB write target.
- btb_wvalid  out  1  BTB write valid bit.
- bht_we  out  1  BHT write enable.
- bht_waddr  out  BHT_IDX_W  BHT write index.
- bht_wdata  out  2  BHT write counter value.
- pred_enable  out  1  tables valid; the NPC generator may predict.
- init_busy  out  1  sweep in progress.
- stat_total  out  64  counted updates.
- stat_correct  out  64  correctly predicted updates.
- stat_dropped  out  32  updates lost during sweep, saturating.

Behaviour:
- FSM has two states: INIT (sweep) and RUN. Sweep index register idx is BHT_IDX_W bits.
- While rst=1:
  - all write enables are 0, pred_enable=0, init_busy=1;
  - all statistics are 0; state<=INIT, idx<=0.
- INIT, one entry per cycle:
  - bht_we=1, bht_waddr=idx, bht_wdata=BHT_INIT.
  - btb_we=(idx<BTB_SET), btb_waddr=idx[BTB_IDX_W-1:0]; wtag, wtarget and wvalid are all 0.
  - idx increments each cycle. At idx==BHT_SET-1 the next state is RUN.
  - The sweep lasts exactly BHT_SET cycles. init_busy=1 and pred_enable=0 throughout.
- RUN:
  - init_busy=0, pred_enable=1.
  - When upd_valid=1, the write happens in the same cycle (combinational outputs) and commits at the next edge. Write values:
    - btb_waddr = upd_pc[BTB_IDX_W+1:2]
    - btb_wtag = upd_pc[31:BTB_IDX_W+2]
    - btb_wtarget = upd_target, btb_wvalid=1
    - bht_waddr = upd_pc[BHT_IDX_W+1:2]
  - bht_wdata is a saturating counter on bht_rdata: taken gives min(rdata+1, 3); not-taken gives max(rdata-1, 0).
  - The counter update never wraps.
  - When upd_valid=0, both write enables are 0 and the other write outputs are don't-care.
- Statistics, on upd_valid in RUN with no flush: stat_total+1, and stat_correct+1 if !upd_mispredict. Both counters are 64-bit and free-running.
- upd_valid during INIT: no table write from the update, sweep unaffected, stat_dropped+1 (saturating at all-ones).
- flush_req (either state):
  - next state INIT, idx<=0, stat_total and stat_correct cleared.
  - flush_req has priority over a simultaneous upd_valid: no update write and no stat increment.
  - stat_dropped is cleared only by rst.
- flush_req during INIT restarts the sweep at idx 0.
- Back-to-back updates to the same BHT index are correct without forwarding, because the table commits at the edge before the next read.

Decomposition:
- Shared package bp_pkg holds:
  - BTB_SET, BHT_SET, BHT_INIT and the derived widths;
  - the state encoding (INIT=1'b0, RUN=1'b1);
  - the PC index/tag slice helper functions, also used by the NPC generator.
- One natural sub-module: bp_sat_counter2, the combinational 2-bit saturating inc/dec.

Test Plan:
1. Reset and sweep:
   - Stimulus: rst=1 for 2 cycles, then 0.
   - Required: init_busy=1 for exactly 4096 cycles; bht_waddr steps 0..4095 with wdata 01; btb_we=1 only for the first 64 cycles with wvalid 0; pred_enable=1 on cycle 4096.
2. Taken update:
   - Stimulus: RUN, upd_pc=0x00001234, taken, target=0x00002000, bht_rdata=2'b10.
   - Required: bht_waddr=0x48D, wdata=11; btb_waddr=0x0D, wtag=0x000012, wtarget=0x00002000, wvalid=1.
3. Saturation:
   - Stimulus: taken with rdata=11; not-taken with rdata=00; not-taken with rdata=10.
   - Required: wdata 11, 00 and 01 respectively.
4. Statistics:
   - Stimulus: 5 updates, 2 with upd_mispredict=1.
   - Required: stat_total=5, stat_correct=3.
5. Flush collision:
   - Stimulus: flush_req and upd_valid in the same cycle.
   - Required: no update write that cycle; next cycle stat_total=0, init_busy=1, bht_waddr=0.
6. Update during sweep:
   - Stimulus: upd_valid at sweep idx 100.
   - Required: bht_waddr=100 with wdata 01 (sweep write, not the update); stat_dropped=1; sweep still ends at cycle 4096.
